// File: rtl/cache_pkg.sv
// Shared types and geometry for the data cache controller.
package cache_pkg;

  localparam int CFG_WORD_SIZE  = 16;
  localparam int CFG_LINE_WORDS = 4;
  localparam int CFG_NUM_LINES  = 4;

  localparam int OFFSET_W = $clog2(CFG_LINE_WORDS);
  localparam int INDEX_W  = $clog2(CFG_NUM_LINES);
  localparam int TAG_W    = CFG_WORD_SIZE - INDEX_W - OFFSET_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } state_t;

  // One cache line as seen by the controller's read port.
  typedef struct packed {
    logic                                          valid;
    logic [TAG_W-1:0]                              tag;
    logic [CFG_LINE_WORDS-1:0][CFG_WORD_SIZE-1:0]  data;
  } line_t;

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage: combinational read by index, registered writes.
// Only the valid bits are reset; tag and data contents are don't-care
// until their line becomes valid.
module dcache_array
  import cache_pkg::*;
#(
  parameter int WORD_SIZE  = CFG_WORD_SIZE,
  parameter int LINE_WORDS = CFG_LINE_WORDS,
  parameter int NUM_LINES  = CFG_NUM_LINES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [INDEX_W-1:0]   rd_index,
  output line_t                rd_line,
  input  logic                 word_we,
  input  logic [INDEX_W-1:0]   wr_index,
  input  logic [OFFSET_W-1:0]  wr_offset,
  input  logic [WORD_SIZE-1:0] wr_word,
  input  logic                 tag_we,
  input  logic [TAG_W-1:0]     wr_tag
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [WORD_SIZE-1:0] data_q [NUM_LINES][LINE_WORDS];

  // Valid bits: cleared on reset, set when a line fill completes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data words, written without reset.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[wr_index] <= wr_tag;
    end
    if (word_we) begin
      data_q[wr_index][wr_offset] <= wr_word;
    end
  end

  // Combinational read of the addressed line.
  always_comb begin
    rd_line       = '0;
    rd_line.valid = valid_q[rd_index];
    rd_line.tag   = tag_q[rd_index];
    for (int w = 0; w < LINE_WORDS; w++) begin
      rd_line.data[w] = data_q[rd_index][w];
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Owns the FSM and the memory-port drive; storage lives in dcache_array.
// Optional: define DCACHE_STATS_EN to add saturating hit/miss counters.
// Geometry of the line record comes from cache_pkg; the parameters below
// must match the package values.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for cpu_read/cpu_write, request captured on exit
// S_LOOKUP    | tag test; write hit updates the cached word
// S_FILL_REQ  | readM2 pulse for the current fill word
// S_FILL_WAIT | two-cycle wait, data2 sampled on the second edge
// S_WR_REQ    | writeM2 pulse, data2 driven
// S_WR_WAIT   | two-cycle wait for memory write completion
// S_DONE      | cpu_done pulse, cpu_rdata valid on loads
module dcache_ctrl
  import cache_pkg::*;
#(
  parameter int WORD_SIZE  = CFG_WORD_SIZE,
  parameter int LINE_WORDS = CFG_LINE_WORDS,
  parameter int NUM_LINES  = CFG_NUM_LINES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_read,
  input  logic                 cpu_write,
  input  logic [WORD_SIZE-1:0] cpu_address,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 cpu_done,
  output logic                 readM2,
  output logic                 writeM2,
  output logic [WORD_SIZE-1:0] address2,
  inout  wire  [WORD_SIZE-1:0] data2
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
`endif
);

  state_t state_q, state_d;

  logic [WORD_SIZE-1:0] req_addr_q;
  logic [WORD_SIZE-1:0] req_wdata_q;
  logic                 req_write_q;
  logic [OFFSET_W-1:0]  fill_cnt_q;
  logic                 wait_q;

  line_t                line;
  logic [INDEX_W-1:0]   req_index;
  logic [OFFSET_W-1:0]  req_offset;
  logic [TAG_W-1:0]     req_tag;
  logic                 hit;
  logic                 last_word;
  logic [OFFSET_W-1:0]  fill_cnt_nxt;

  logic                 word_we;
  logic [OFFSET_W-1:0]  wr_offset;
  logic [WORD_SIZE-1:0] wr_word;
  logic                 tag_we;

  assign req_offset   = req_addr_q[OFFSET_W-1:0];
  assign req_index    = req_addr_q[OFFSET_W +: INDEX_W];
  assign req_tag      = req_addr_q[WORD_SIZE-1 -: TAG_W];
  assign hit          = line.valid && (line.tag == req_tag);
  assign last_word    = (fill_cnt_q == {OFFSET_W{1'b1}});
  assign fill_cnt_nxt = fill_cnt_q + OFFSET_W'(1);

  // The bus is only ours during the write pulse; memory owns it otherwise.
  assign data2 = writeM2 ? req_wdata_q : {WORD_SIZE{1'bz}};

  dcache_array #(
    .WORD_SIZE  (WORD_SIZE),
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES)
  ) u_array (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_index  (req_index),
    .rd_line   (line),
    .word_we   (word_we),
    .wr_index  (req_index),
    .wr_offset (wr_offset),
    .wr_word   (wr_word),
    .tag_we    (tag_we),
    .wr_tag    (req_tag)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, handshake outputs and array write controls.
  always_comb begin
    state_d   = state_q;
    readM2    = 1'b0;
    writeM2   = 1'b0;
    cpu_done  = 1'b0;
    cpu_rdata = '0;
    word_we   = 1'b0;
    wr_offset = fill_cnt_q;
    wr_word   = data2;
    tag_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_read || cpu_write) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (req_write_q) begin
          state_d   = S_WR_REQ;
          word_we   = hit;
          wr_offset = req_offset;
          wr_word   = req_wdata_q;
        end else if (hit) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FILL_REQ;
        end
      end
      S_FILL_REQ: begin
        readM2  = 1'b1;
        state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (wait_q) begin
          word_we = 1'b1;
          tag_we  = last_word;
          state_d = last_word ? S_DONE : S_FILL_REQ;
        end
      end
      S_WR_REQ: begin
        writeM2 = 1'b1;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (wait_q) state_d = S_DONE;
      end
      S_DONE: begin
        cpu_done  = 1'b1;
        cpu_rdata = req_write_q ? '0 : line.data[req_offset];
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, fill word counter, wait counter and memory address.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_write_q <= 1'b0;
      fill_cnt_q  <= '0;
      wait_q      <= 1'b0;
      address2    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wait_q <= 1'b0;
          if (cpu_read || cpu_write) begin
            req_addr_q  <= cpu_address;
            req_wdata_q <= cpu_wdata;
            req_write_q <= cpu_write;
          end
        end
        S_LOOKUP: begin
          if (req_write_q) begin
            address2 <= req_addr_q;
          end else if (!hit) begin
            fill_cnt_q <= '0;
            address2   <= {req_addr_q[WORD_SIZE-1:OFFSET_W], {OFFSET_W{1'b0}}};
          end
        end
        S_FILL_WAIT: begin
          wait_q <= ~wait_q;
          if (wait_q && !last_word) begin
            fill_cnt_q <= fill_cnt_nxt;
            address2   <= {req_addr_q[WORD_SIZE-1:OFFSET_W], fill_cnt_nxt};
          end
        end
        S_WR_WAIT: begin
          wait_q <= ~wait_q;
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // Saturating per-request hit/miss counters, updated in LOOKUP.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (hit) begin
        if (hit_count != 16'hffff) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hffff) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a small behavioural memory on port 2.
// Expected memory operations and load data are queued when a request is
// issued and compared against what the monitor observed afterwards.
module tb_dcache_ctrl;

  localparam logic [15:0] BUS_IDLE = 16'hffff;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [15:0] cpu_address = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_done;
  logic        readM2;
  logic        writeM2;
  logic [15:0] address2;
  wire  [15:0] data2;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_read    (cpu_read),
    .cpu_write   (cpu_write),
    .cpu_address (cpu_address),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_done    (cpu_done),
    .readM2      (readM2),
    .writeM2     (writeM2),
    .address2    (address2),
    .data2       (data2)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  // Weak keeper so an undriven bus reads as a known idle pattern.
  assign (weak0, weak1) data2 = BUS_IDLE;

  // Behavioural memory: request sampled at E, read data on the bus for the
  // cycle ending at E+2, writes taken at E.
  logic [15:0] mem [256];
  logic        mem_drive;
  logic [15:0] mem_rdata;
  logic [7:0]  pend_addr;
  logic [1:0]  stage;

  assign data2 = mem_drive ? mem_rdata : 16'bz;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h00] <= 16'h9023;
      mem[8'h01] <= 16'h0001;
      mem[8'h02] <= 16'hffff;
      mem[8'h03] <= 16'h0000;
      mem[8'h23] <= 16'h6000;
      mem_drive  <= 1'b0;
      mem_rdata  <= '0;
      pend_addr  <= '0;
      stage      <= 2'd0;
    end else begin
      if (writeM2) mem[address2[7:0]] <= data2;
      case (stage)
        2'd0: if (readM2) begin
          pend_addr <= address2[7:0];
          stage     <= 2'd1;
        end
        2'd1: begin
          mem_drive <= 1'b1;
          mem_rdata <= mem[pend_addr];
          stage     <= 2'd2;
        end
        default: begin
          mem_drive <= 1'b0;
          stage     <= 2'd0;
        end
      endcase
    end
  end

  // Monitor: records memory-port pulses and completions.
  int          cyc = 0;
  logic        mo_wr   [64];
  logic [15:0] mo_addr [64];
  logic [15:0] mo_data [64];
  int          mo_cyc  [64];
  int          mo_n = 0;
  logic [15:0] dn_data [64];
  int          dn_n = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if ((readM2 || writeM2) && mo_n < 64) begin
      mo_wr[mo_n]   <= writeM2;
      mo_addr[mo_n] <= address2;
      mo_data[mo_n] <= data2;
      mo_cyc[mo_n]  <= cyc;
      mo_n          <= mo_n + 1;
    end
    if (cpu_done && dn_n < 64) begin
      dn_data[dn_n] <= cpu_rdata;
      dn_n          <= dn_n + 1;
    end
  end

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } mop_t;

  mop_t        exp_mq[$];
  logic [15:0] exp_dq[$];
  int          errors = 0;
  int          checks = 0;
  int          mo_rd = 0;
  int          dn_rd = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_fill(input logic [15:0] base);
    for (int w = 0; w < 4; w++) exp_mq.push_back('{1'b0, base + 16'(w), 16'h0000});
  endtask

  task automatic exp_write(input logic [15:0] a, input logic [15:0] d);
    exp_mq.push_back('{1'b1, a, d});
  endtask

  // Compare everything the monitor has seen against the queued expectations.
  task automatic drain();
    mop_t e;
    int   prev_cyc;
    logic have_prev;
    have_prev = 1'b0;
    prev_cyc  = 0;
    while (mo_rd < mo_n) begin
      if (exp_mq.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_mem_op: observed wr=%0d addr=%0h expected none",
               mo_wr[mo_rd], mo_addr[mo_rd]);
      end else begin
        e = exp_mq.pop_front();
        chk("mem_op_kind", 32'(mo_wr[mo_rd]), 32'(e.wr));
        chk("mem_op_addr", 32'(mo_addr[mo_rd]), 32'(e.addr));
        if (e.wr) begin
          chk("mem_wr_data", 32'(mo_data[mo_rd]), 32'(e.data));
        end else begin
          if (have_prev) chk("readM2_spacing", 32'(mo_cyc[mo_rd] - prev_cyc), 32'd3);
          prev_cyc  = mo_cyc[mo_rd];
          have_prev = 1'b1;
        end
      end
      mo_rd++;
    end
    chk("missing_mem_ops", 32'(exp_mq.size()), 32'd0);
    exp_mq.delete();
    while (dn_rd < dn_n) begin
      if (exp_dq.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_done: observed rdata=%0h expected none", dn_data[dn_rd]);
      end else begin
        chk("cpu_rdata", 32'(dn_data[dn_rd]), 32'(exp_dq.pop_front()));
      end
      dn_rd++;
    end
    chk("missing_done", 32'(exp_dq.size()), 32'd0);
    exp_dq.delete();
  endtask

  // Issue one request, hold it until cpu_done, check latency and pulse width.
  // Latency counts edges from the accepting edge to the edge that ends DONE.
  task automatic req(input logic wr, input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] exp_rdata, input int lat);
    int   k;
    logic got;
    exp_dq.push_back(exp_rdata);
    @(negedge clk);
    cpu_read    = !wr;
    cpu_write   = wr;
    cpu_address = a;
    cpu_wdata   = d;
    @(posedge clk);
    k   = 0;
    got = 1'b0;
    while (!got && k < 64) begin
      @(posedge clk);
      #1;
      k++;
      if (cpu_done) got = 1'b1;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(k + 1), 32'(lat));
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(cpu_done), 32'd0);
    drain();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_readM2"},    32'(readM2),    32'd0);
    chk({tag, "_writeM2"},   32'(writeM2),   32'd0);
    chk({tag, "_cpu_done"},  32'(cpu_done),  32'd0);
    chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    chk({tag, "_address2"},  32'(address2),  32'd0);
    chk({tag, "_data2"},     32'(data2),     32'(BUS_IDLE));
  endtask

  initial begin
    int n0;
    int k;

    // Reset values.
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    reset_n = 1'b1;

    // 1: cold read miss fills line 0.
    exp_fill(16'h0000);
    req(1'b0, 16'h0001, 16'h0000, 16'h0001, 14);

    // 2: read hit in the same line.
    req(1'b0, 16'h0002, 16'h0000, 16'hffff, 2);

    // 3: write hit goes to memory and updates the line.
    exp_write(16'h0002, 16'h1234);
    req(1'b1, 16'h0002, 16'h1234, 16'h0000, 5);
`ifdef DCACHE_STATS_EN
    chk("hit_count",  32'(hit_count),  32'd2);
    chk("miss_count", 32'(miss_count), 32'd1);
`endif
    req(1'b0, 16'h0002, 16'h0000, 16'h1234, 2);

    // 4: write miss does not allocate; the later read fills and evicts line 0.
    exp_write(16'h0023, 16'habcd);
    req(1'b1, 16'h0023, 16'habcd, 16'h0000, 5);
    chk("mem_after_write_miss", 32'(mem[8'h23]), 32'h0000abcd);
    exp_fill(16'h0020);
    req(1'b0, 16'h0023, 16'h0000, 16'habcd, 14);
    exp_fill(16'h0000);
    req(1'b0, 16'h0001, 16'h0000, 16'h0001, 14);

    // 5: reset during the third fill word abandons the transaction.
    for (int w = 0; w < 3; w++) exp_mq.push_back('{1'b0, 16'h0020 + 16'(w), 16'h0000});
    n0 = mo_n;
    @(negedge clk);
    cpu_read    = 1'b1;
    cpu_address = 16'h0021;
    k = 0;
    while (mo_n < n0 + 3 && k < 60) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("third_fill_seen", 32'(mo_n - n0), 32'd3);
    reset_n  = 1'b0;
    cpu_read = 1'b0;
    @(posedge clk);
    #1;
    chk_quiet("abort");
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    drain();
    exp_fill(16'h0000);
    req(1'b0, 16'h0001, 16'h0000, 16'h0001, 14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
